// File: rtl/spi_load_sequencer.sv
// Streams the CNN image, filter and weight stores into the accelerator over SPI,
// runs the core, then reads back the classification result.
module spi_load_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        go,
    output logic [11:0] src_addr,
    output logic        src_rd,
    input  logic [7:0]  src_data,
    output logic [15:0] spi_addr,
    output logic [15:0] spi_wr_data,
    output logic [15:0] spi_nod,
    output logic        spi_start,
    input  logic        spi_done,
    input  logic        spi_done_sign,
    input  logic [15:0] spi_rd_data,
    output logic        cnn_start,
    input  logic        cnn_finish,
    output logic [15:0] result,
    output logic        result_valid,
    output logic        busy,
    output logic        done
);

    typedef enum logic [3:0] {
        IDLE, FETCH, START, XFER, NEXT, RUN, RUNWAIT, RDSTART, RDWAIT, DONE
    } state_t;

    typedef enum logic [1:0] {SEG_IMG, SEG_FLT, SEG_W1, SEG_W2} seg_t;

    state_t      state_q;
    seg_t        seg_q, seg_d;
    logic [3:0]  outer_q, outer_d;
    logic [4:0]  inner_q, inner_d;
    logic        last_txn;
    logic [11:0] src_addr_q;
    logic        src_rd_q;
    logic        rd_pend_q;
    logic [15:0] spi_addr_q;
    logic [15:0] spi_wr_data_q;
    logic [15:0] spi_nod_q;
    logic        spi_start_q;
    logic        cnn_start_q;
    logic [15:0] result_q;
    logic        result_valid_q;
    logic        busy_q;
    logic        done_q;

    // outer is the filter bank or neuron index, inner the row index
    function automatic logic [15:0] txnAddr(input seg_t seg, input logic [3:0] outer,
                                            input logic [4:0] inner);
        case (seg)
            SEG_IMG: txnAddr = {1'b1, 3'b000, 2'b00, inner, 5'b00000};
            SEG_FLT: txnAddr = {1'b1, 3'b001, 6'b000000, outer[1:0], inner[1:0], 2'b00};
            SEG_W1:  txnAddr = {1'b1, 3'b010, outer, inner, 3'b000};
            default: txnAddr = {1'b1, 3'b011, outer, 8'h00};
        endcase
    endfunction

    function automatic logic [15:0] txnNod(input seg_t seg);
        case (seg)
            SEG_IMG: txnNod = 16'd28;
            SEG_FLT: txnNod = 16'd3;
            SEG_W1:  txnNod = 16'd7;
            default: txnNod = 16'd10;
        endcase
    endfunction

    always_comb begin
        seg_d    = seg_q;
        outer_d  = outer_q;
        inner_d  = inner_q;
        last_txn = 1'b0;
        case (seg_q)
            SEG_IMG: begin
                if (inner_q == 5'd27) begin
                    seg_d   = SEG_FLT;
                    outer_d = 4'd0;
                    inner_d = 5'd0;
                end else begin
                    inner_d = inner_q + 5'd1;
                end
            end
            SEG_FLT: begin
                if (inner_q == 5'd2) begin
                    inner_d = 5'd0;
                    if (outer_q == 4'd3) begin
                        seg_d   = SEG_W1;
                        outer_d = 4'd1;
                    end else begin
                        outer_d = outer_q + 4'd1;
                    end
                end else begin
                    inner_d = inner_q + 5'd1;
                end
            end
            SEG_W1: begin
                if (inner_q == 5'd27) begin
                    inner_d = 5'd0;
                    if (outer_q == 4'd10) begin
                        seg_d   = SEG_W2;
                        outer_d = 4'd1;
                    end else begin
                        outer_d = outer_q + 4'd1;
                    end
                end else begin
                    inner_d = inner_q + 5'd1;
                end
            end
            default: begin
                if (outer_q == 4'd14) begin
                    last_txn = 1'b1;
                end else begin
                    outer_d = outer_q + 4'd1;
                end
            end
        endcase
    end

    // A store read is in flight while src_rd_q or rd_pend_q is set; FETCH and
    // NEXT hold off the next transaction until the word has landed in spi_wr_data.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            seg_q          <= SEG_IMG;
            outer_q        <= 4'd0;
            inner_q        <= 5'd0;
            src_addr_q     <= 12'd0;
            src_rd_q       <= 1'b0;
            rd_pend_q      <= 1'b0;
            spi_addr_q     <= 16'd0;
            spi_wr_data_q  <= 16'd0;
            spi_nod_q      <= 16'd0;
            spi_start_q    <= 1'b0;
            cnn_start_q    <= 1'b0;
            result_q       <= 16'd0;
            result_valid_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            src_rd_q  <= 1'b0;
            rd_pend_q <= src_rd_q;
            if (rd_pend_q) begin
                spi_wr_data_q <= {8'h00, src_data};
            end
            case (state_q)
                IDLE: begin
                    if (go) begin
                        state_q    <= FETCH;
                        busy_q     <= 1'b1;
                        src_addr_q <= 12'd0;
                        src_rd_q   <= 1'b1;
                        seg_q      <= SEG_IMG;
                        outer_q    <= 4'd0;
                        inner_q    <= 5'd0;
                        spi_addr_q <= txnAddr(SEG_IMG, 4'd0, 5'd0);
                        spi_nod_q  <= txnNod(SEG_IMG);
                    end
                end
                FETCH: begin
                    if (!src_rd_q && !rd_pend_q) begin
                        state_q     <= START;
                        spi_start_q <= 1'b1;
                    end
                end
                START: begin
                    spi_start_q <= 1'b0;
                    state_q     <= XFER;
                end
                XFER: begin
                    if (spi_done_sign) begin
                        src_addr_q <= src_addr_q + 12'd1;
                        src_rd_q   <= 1'b1;
                    end
                    if (spi_done) begin
                        state_q <= NEXT;
                    end
                end
                NEXT: begin
                    if (!src_rd_q && !rd_pend_q) begin
                        if (last_txn) begin
                            state_q     <= RUN;
                            cnn_start_q <= 1'b1;
                        end else begin
                            seg_q       <= seg_d;
                            outer_q     <= outer_d;
                            inner_q     <= inner_d;
                            spi_addr_q  <= txnAddr(seg_d, outer_d, inner_d);
                            spi_nod_q   <= txnNod(seg_d);
                            spi_start_q <= 1'b1;
                            state_q     <= START;
                        end
                    end
                end
                RUN: begin
                    cnn_start_q <= 1'b0;
                    state_q     <= RUNWAIT;
                end
                RUNWAIT: begin
                    if (cnn_finish) begin
                        state_q       <= RDSTART;
                        spi_addr_q    <= 16'h4001;
                        spi_nod_q     <= 16'd15;
                        spi_wr_data_q <= 16'd0;
                        spi_start_q   <= 1'b1;
                    end
                end
                RDSTART: begin
                    spi_start_q <= 1'b0;
                    state_q     <= RDWAIT;
                end
                RDWAIT: begin
                    if (spi_done) begin
                        result_q       <= spi_rd_data;
                        result_valid_q <= 1'b1;
                        done_q         <= 1'b1;
                        state_q        <= DONE;
                    end
                end
                DONE: begin
                    result_valid_q <= 1'b0;
                    done_q         <= 1'b0;
                    busy_q         <= 1'b0;
                    state_q        <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign src_addr     = src_addr_q;
    assign src_rd       = src_rd_q;
    assign spi_addr     = spi_addr_q;
    assign spi_wr_data  = spi_wr_data_q;
    assign spi_nod      = spi_nod_q;
    assign spi_start    = spi_start_q;
    assign cnn_start    = cnn_start_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_spi_load_sequencer.sv
// Self-checking bench for spi_load_sequencer: a store model and SPI/CNN responders
// drive full load/run/readback sequences against a transaction-schedule model.
module tb_spi_load_sequencer;

    localparam int TOTAL_TXNS = 334;

    logic        clk = 1'b0;
    logic        reset;
    logic        go;
    logic [11:0] src_addr;
    logic        src_rd;
    logic [7:0]  src_data;
    logic [15:0] spi_addr;
    logic [15:0] spi_wr_data;
    logic [15:0] spi_nod;
    logic        spi_start;
    logic        spi_done;
    logic        spi_done_sign;
    logic [15:0] spi_rd_data;
    logic        cnn_start;
    logic        cnn_finish;
    logic [15:0] result;
    logic        result_valid;
    logic        busy;
    logic        done;

    int total = 0;
    int bad = 0;
    int wordIdx = 0;

    logic [7:0]  mem [0:4095];
    logic [15:0] expAddr[$];
    logic [15:0] expNod[$];
    logic [15:0] obsAddr[$];
    logic [15:0] obsNod[$];
    logic [15:0] obsFirst[$];

    typedef struct {
        int          txn;
        logic [15:0] addr;
        logic [15:0] nod;
        logic [15:0] first;
    } vec_t;

    vec_t vecs [8];

    spi_load_sequencer dut (
        .clk          (clk),
        .reset        (reset),
        .go           (go),
        .src_addr     (src_addr),
        .src_rd       (src_rd),
        .src_data     (src_data),
        .spi_addr     (spi_addr),
        .spi_wr_data  (spi_wr_data),
        .spi_nod      (spi_nod),
        .spi_start    (spi_start),
        .spi_done     (spi_done),
        .spi_done_sign(spi_done_sign),
        .spi_rd_data  (spi_rd_data),
        .cnn_start    (cnn_start),
        .cnn_finish   (cnn_finish),
        .result       (result),
        .result_valid (result_valid),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (src_rd) src_data <= mem[src_addr];
    end

    initial begin
        #950000;
        $display("[TB] FAIL watchdog expired: total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic g, input logic fin, input logic sgn, input logic dn);
        go            = g;
        cnn_finish    = fin;
        spi_done_sign = sgn;
        spi_done      = dn;
        @(negedge clk);
        go            = 1'b0;
        cnn_finish    = 1'b0;
        spi_done_sign = 1'b0;
        spi_done      = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // The write schedule written as plain nested loops over rows, banks and neurons
    task automatic buildModel();
        expAddr.delete();
        expNod.delete();
        for (int r = 0; r < 28; r++) begin
            expAddr.push_back(16'h8000 + 16'(r * 32));
            expNod.push_back(16'd28);
        end
        for (int b = 0; b < 4; b++) begin
            for (int r = 0; r < 3; r++) begin
                expAddr.push_back(16'h9000 + 16'(b * 16 + r * 4));
                expNod.push_back(16'd3);
            end
        end
        for (int n = 1; n <= 10; n++) begin
            for (int r = 0; r < 28; r++) begin
                expAddr.push_back(16'hA000 + 16'(n * 256 + r * 8));
                expNod.push_back(16'd7);
            end
        end
        for (int n = 1; n <= 14; n++) begin
            expAddr.push_back(16'hB000 + 16'(n * 256));
            expNod.push_back(16'd10);
        end
    endtask

    task automatic serveTxn(input int idx, input bit coin, input int abortWord,
                            input bit glitch, output bit ok);
        int          t;
        int          nodE;
        logic [15:0] a;
        logic [15:0] n;
        bit          stable;
        ok = 1'b0;
        t  = 0;
        while (spi_start !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (spi_start !== 1'b1) begin
            checkOutput($sformatf("txn%0d start timeout", idx), 32'd0, 32'd1);
            return;
        end
        a      = spi_addr;
        n      = spi_nod;
        nodE   = int'(expNod[idx]);
        stable = 1'b1;
        obsAddr.push_back(a);
        obsNod.push_back(n);
        obsFirst.push_back(spi_wr_data);
        checkOutput($sformatf("txn%0d spi_addr", idx), 32'(a), 32'(expAddr[idx]));
        checkOutput($sformatf("txn%0d spi_nod", idx), 32'(n), 32'(expNod[idx]));
        @(negedge clk);
        checkOutput($sformatf("txn%0d spi_start width", idx), 32'(spi_start), 32'd0);
        for (int w = 0; w < nodE; w++) begin
            if (glitch && idx == 3 && w == 1) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
            if (glitch && idx == 5 && w == 2) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
            idle($urandom_range(2, 4));
            if (w == abortWord) begin
                #2 reset = 1'b1;
                #1;
                checkOutput("async reset src_addr", 32'(src_addr), 32'd0);
                checkOutput("async reset spi_addr", 32'(spi_addr), 32'd0);
                checkOutput("async reset spi_nod", 32'(spi_nod), 32'd0);
                checkOutput("async reset spi_wr_data", 32'(spi_wr_data), 32'd0);
                checkOutput("async reset busy", 32'(busy), 32'd0);
                checkOutput("async reset strobes",
                            32'({src_rd, spi_start, cnn_start, result_valid, done}), 32'd0);
                checkOutput("async reset result", 32'(result), 32'd0);
                @(negedge clk);
                reset = 1'b0;
                @(negedge clk);
                return;
            end
            if (spi_addr !== a || spi_nod !== n) stable = 1'b0;
            checkOutput($sformatf("txn%0d word%0d data", idx, w), 32'(spi_wr_data),
                        32'({8'h00, mem[wordIdx]}));
            wordIdx++;
            applyStimulus(1'b0, 1'b0, 1'b1, coin && (w == nodE - 1));
        end
        if (!coin) begin
            idle($urandom_range(0, 2));
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        end
        checkOutput($sformatf("txn%0d addr/nod stable", idx), 32'(stable), 32'd1);
        ok = 1'b1;
    endtask

    // coinMode 0: random spi_done placement, 1: always coincident with last word
    task automatic runSequence(input bit glitch, input int abortTxn, input bit coinMode,
                               input logic [15:0] rdVal, input int finDelay);
        bit ok;
        int t;
        int starts;
        int cnnHigh;
        obsAddr.delete();
        obsNod.delete();
        obsFirst.delete();
        wordIdx = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("busy after go", 32'(busy), 32'd1);
        checkOutput("src_addr after go", 32'(src_addr), 32'd0);
        checkOutput("src_rd after go", 32'(src_rd), 32'd1);
        for (int i = 0; i < TOTAL_TXNS; i++) begin
            serveTxn(i, coinMode ? 1'b1 : 1'($urandom_range(0, 1)),
                     (i == abortTxn) ? 3 : -1, glitch, ok);
            if (!ok) return;
        end
        t = 0;
        while (cnn_start !== 1'b1 && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (cnn_start !== 1'b1) begin
            checkOutput("cnn_start timeout", 32'd0, 32'd1);
            return;
        end
        checkOutput("src_addr at RUN", 32'(src_addr), 32'd2920);
        checkOutput("spi_addr held at RUN", 32'(spi_addr), 32'(expAddr[TOTAL_TXNS - 1]));
        starts  = 0;
        cnnHigh = 0;
        for (int c = 0; c < finDelay; c++) begin
            if (glitch && c == finDelay / 2) begin
                spi_done_sign = 1'b1;
                spi_done      = 1'b1;
            end else begin
                spi_done_sign = 1'b0;
                spi_done      = 1'b0;
            end
            @(negedge clk);
            if (spi_start) starts++;
            if (cnn_start) cnnHigh++;
        end
        spi_done_sign = 1'b0;
        spi_done      = 1'b0;
        checkOutput("spi_start during RUNWAIT", 32'(starts), 32'd0);
        checkOutput("extra cnn_start cycles", 32'(cnnHigh), 32'd0);
        checkOutput("busy during RUNWAIT", 32'(busy), 32'd1);
        checkOutput("src_addr during RUNWAIT", 32'(src_addr), 32'd2920);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        t = 0;
        while (spi_start !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (spi_start !== 1'b1) begin
            checkOutput("readback start timeout", 32'd0, 32'd1);
            return;
        end
        checkOutput("read spi_addr", 32'(spi_addr), 32'h4001);
        checkOutput("read spi_nod", 32'(spi_nod), 32'd15);
        checkOutput("read spi_wr_data", 32'(spi_wr_data), 32'd0);
        idle(3);
        spi_rd_data = rdVal;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("result_valid pulse", 32'(result_valid), 32'd1);
        checkOutput("done pulse", 32'(done), 32'd1);
        checkOutput("result value", 32'(result), 32'(rdVal));
        @(negedge clk);
        checkOutput("result_valid cleared", 32'(result_valid), 32'd0);
        checkOutput("done cleared", 32'(done), 32'd0);
        checkOutput("busy cleared", 32'(busy), 32'd0);
        checkOutput("result held", 32'(result), 32'(rdVal));
    endtask

    initial begin
        reset         = 1'b1;
        go            = 1'b0;
        spi_done      = 1'b0;
        spi_done_sign = 1'b0;
        spi_rd_data   = 16'd0;
        cnn_finish    = 1'b0;
        src_data      = 8'd0;
        for (int k = 0; k < 4096; k++) mem[k] = 8'(k);
        buildModel();

        // Schedule boundaries; first word is store word k = k[7:0]
        vecs[0] = '{0,   16'h8000, 16'd28, 16'h0000};
        vecs[1] = '{27,  16'h8360, 16'd28, 16'h00F4};
        vecs[2] = '{28,  16'h9000, 16'd3,  16'h0010};
        vecs[3] = '{39,  16'h9038, 16'd3,  16'h0031};
        vecs[4] = '{40,  16'hA100, 16'd7,  16'h0034};
        vecs[5] = '{319, 16'hAAD8, 16'd7,  16'h00D5};
        vecs[6] = '{320, 16'hB100, 16'd10, 16'h00DC};
        vecs[7] = '{333, 16'hBE00, 16'd10, 16'h005E};

        idle(3);
        checkOutput("reset src_addr", 32'(src_addr), 32'd0);
        checkOutput("reset spi_addr", 32'(spi_addr), 32'd0);
        checkOutput("reset spi_nod", 32'(spi_nod), 32'd0);
        checkOutput("reset result", 32'(result), 32'd0);
        checkOutput("reset strobes",
                    32'({src_rd, spi_start, cnn_start, result_valid, busy, done}), 32'd0);
        reset = 1'b0;
        idle(2);

        $display("[TB] run 1: full sequence with stray go/cnn_finish/spi_done");
        runSequence(1'b1, -1, 1'b0, 16'h002C, 500);
        for (int i = 0; i < 8; i++) begin
            if (vecs[i].txn < obsAddr.size()) begin
                checkOutput($sformatf("table txn%0d addr", vecs[i].txn),
                            32'(obsAddr[vecs[i].txn]), 32'(vecs[i].addr));
                checkOutput($sformatf("table txn%0d nod", vecs[i].txn),
                            32'(obsNod[vecs[i].txn]), 32'(vecs[i].nod));
                checkOutput($sformatf("table txn%0d first word", vecs[i].txn),
                            32'(obsFirst[vecs[i].txn]), 32'(vecs[i].first));
            end else begin
                checkOutput($sformatf("table txn%0d not observed", vecs[i].txn), 32'd0, 32'd1);
            end
        end

        $display("[TB] run 2: reset during W1 transaction 50");
        idle(5);
        runSequence(1'b0, 90, 1'b0, 16'h0000, 10);
        checkOutput("idle after abort busy", 32'(busy), 32'd0);
        checkOutput("idle after abort src_addr", 32'(src_addr), 32'd0);

        $display("[TB] run 3: random store, spi_done always with last word");
        for (int k = 0; k < 4096; k++) mem[k] = 8'($urandom);
        idle(3);
        runSequence(1'b0, -1, 1'b1, 16'($urandom), $urandom_range(20, 60));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
